vx_mem_perf_tracker: RTL and testbench
======================================

VX_MEM_PERF_TRACKER -- requirements
Module: VX_mem_perf_tracker

Interface
- REQ-001: Parameter PERF_CTR_BITS, default 44, SHALL set the width of every performance counter output.
- REQ-002: Parameter PENDING_BITS, default 8, SHALL set the width of the outstanding-read counter (max 2^PENDING_BITS-1).
- REQ-003: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
- REQ-004: reset  input  1  SHALL be a synchronous, active-low reset.
- REQ-005: clear  input  1  SHALL be a synchronous counter clear, active-high.
- REQ-006: mem_req_valid  input  1  SHALL be the memory request valid bit.
- REQ-007: mem_req_rw  input  1  SHALL be the request type: 1 = write, 0 = read.
- REQ-008: mem_req_ready  input  1  SHALL be the memory request ready bit.
- REQ-009: mem_rsp_valid  input  1  SHALL be the memory read-response valid bit.
- REQ-010: mem_rsp_ready  input  1  SHALL be the memory read-response ready bit.
- REQ-011: mem_reads  output  PERF_CTR_BITS  SHALL be the accepted read-request count.
- REQ-012: mem_writes  output  PERF_CTR_BITS  SHALL be the accepted write-request count.
- REQ-013: mem_latency  output  PERF_CTR_BITS  SHALL be the accumulated read-latency sum in cycles.
- REQ-014: pending_reads  output  PENDING_BITS  SHALL be the current outstanding-read count.
- REQ-015: perf_error  output  1  SHALL be a sticky flag for outstanding-counter overflow or underflow.

Function
- REQ-016: Event definitions:
  - read fire = mem_req_valid & mem_req_ready & ~mem_req_rw.
  - write fire = mem_req_valid & mem_req_ready & mem_req_rw.
  - rsp fire = mem_rsp_valid & mem_rsp_ready.
- REQ-017: mem_reads SHALL increment by 1 in the cycle after each read fire.
- REQ-018: mem_writes SHALL increment by 1 in the cycle after each write fire.
- REQ-019: pending_reads SHALL update one cycle after the events:
  - +1 on read fire alone;
  - -1 on rsp fire alone;
  - unchanged on simultaneous read fire and rsp fire.
- REQ-020: Each cycle, mem_latency SHALL add the registered (pre-update) pending_reads value, so a read with N-cycle fire-to-rsp latency contributes N.
- REQ-021: mem_reads, mem_writes and mem_latency SHALL wrap modulo 2^PERF_CTR_BITS with no saturation or flag.
- REQ-022: Read fire alone at pending_reads = max SHALL hold pending_reads at max and set perf_error.
- REQ-023: Rsp fire alone at pending_reads = 0 SHALL hold pending_reads at 0 and set perf_error.
- REQ-024: perf_error SHALL remain set until reset or clear.
- REQ-025: When clear=1, mem_reads, mem_writes, mem_latency and perf_error SHALL be 0 next cycle.
- REQ-026: clear SHALL NOT modify pending_reads; events in the clear cycle SHALL update pending_reads normally.
- REQ-027: All outputs SHALL be registered; the block SHALL never drive ready/valid and SHALL not affect the monitored handshake.

Reset
- REQ-028: With reset=0 at a clock edge, all outputs SHALL be 0 next cycle, regardless of clear or events in that cycle.
- REQ-029: Reset asserted mid-transaction SHALL discard outstanding reads; post-reset responses are handled per REQ-023.

Structure
- REQ-030: A shared performance package SHALL hold the default counter width and a packed struct {reads, writes, latency} for memory perf counters.
- REQ-031: The outstanding counter SHALL be a sub-module VX_pending_counter providing parameterised width, saturating up/down counting and an overflow/underflow pulse.
- REQ-032: The implementation SHALL contain no combinational path from inputs to outputs.

Verification
- REQ-033: Issue 3 reads, each answered 5 cycles after its fire, non-overlapping -> mem_reads=3, mem_latency=15, pending_reads=0, perf_error=0.
- REQ-034: Issue 4 back-to-back reads, then 4 back-to-back responses starting 2 cycles after the last fire -> mem_latency=1+2+3+4+4+3+2+1=20.
- REQ-035: Assert read fire and rsp fire together at pending_reads=2 -> pending_reads stays 2 and mem_reads increments by 1.
- REQ-036: Send rsp fire at pending_reads=0 -> perf_error=1 next cycle and pending_reads=0; then clear -> perf_error=0 and counters=0.
- REQ-037: With PERF_CTR_BITS=4, issue 17 writes -> mem_writes=1; with PENDING_BITS=2, issue 4 reads with no responses -> pending_reads=3 and perf_error=1.
- REQ-038: Assert reset=0 with 2 reads outstanding -> all outputs 0 next cycle; counting resumes correctly after reset=1.

Source files
------------

// File: rtl/vx_mem_perf_tracker_pkg.sv
// Shared memory performance-counter definitions: default widths and counter/event bundles.
package vx_mem_perf_tracker_pkg;

  localparam int unsigned PerfCtrBitsDflt = 44;
  localparam int unsigned PendingBitsDflt = 8;

  typedef struct packed {
    logic [PerfCtrBitsDflt-1:0] reads;
    logic [PerfCtrBitsDflt-1:0] writes;
    logic [PerfCtrBitsDflt-1:0] latency;
  } mem_perf_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic rsp;
  } mem_evt_t;

endpackage

// File: rtl/vx_mem_perf_tracker_pending_counter.sv
// Saturating up/down counter of outstanding reads; err_o pulses when a step would over/underflow.
module vx_mem_perf_tracker_pending_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             err_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    err_o   = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == '1) err_o = 1'b1;
        else               count_d = count_q + Width'(1);
      end
      2'b01: begin
        if (count_q == '0) err_o = 1'b1;
        else               count_d = count_q - Width'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/vx_mem_perf_tracker.sv
// Passive monitor of a memory request/response handshake: read/write counts, latency sum, pending reads.
module vx_mem_perf_tracker
  import vx_mem_perf_tracker_pkg::*;
#(
  parameter int unsigned PerfCtrBits = PerfCtrBitsDflt,
  parameter int unsigned PendingBits = PendingBitsDflt
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   mem_req_valid_i,
  input  logic                   mem_req_rw_i,
  input  logic                   mem_req_ready_i,
  input  logic                   mem_rsp_valid_i,
  input  logic                   mem_rsp_ready_i,
  output logic [PerfCtrBits-1:0] mem_reads_o,
  output logic [PerfCtrBits-1:0] mem_writes_o,
  output logic [PerfCtrBits-1:0] mem_latency_o,
  output logic [PendingBits-1:0] pending_reads_o,
  output logic                   perf_error_o
);

  mem_evt_t evt;
  assign evt.rd  = mem_req_valid_i & mem_req_ready_i & ~mem_req_rw_i;
  assign evt.wr  = mem_req_valid_i & mem_req_ready_i & mem_req_rw_i;
  assign evt.rsp = mem_rsp_valid_i & mem_rsp_ready_i;

  logic [PendingBits-1:0] pending;
  logic                   pend_err;

  vx_mem_perf_tracker_pending_counter #(
    .Width (PendingBits)
  ) u_pending (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (evt.rd),
    .dec_i   (evt.rsp),
    .count_o (pending),
    .err_o   (pend_err)
  );

  logic [PerfCtrBits-1:0] reads_q, reads_d;
  logic [PerfCtrBits-1:0] writes_q, writes_d;
  logic [PerfCtrBits-1:0] latency_q, latency_d;
  logic                   error_q, error_d;

  always_comb begin
    reads_d   = reads_q + PerfCtrBits'(evt.rd);
    writes_d  = writes_q + PerfCtrBits'(evt.wr);
    // Each cycle a read stays outstanding adds one cycle to the latency sum.
    latency_d = latency_q + PerfCtrBits'(pending);
    error_d   = error_q | pend_err;
    if (clear_i) begin
      reads_d   = '0;
      writes_d  = '0;
      latency_d = '0;
      error_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reads_q   <= '0;
      writes_q  <= '0;
      latency_q <= '0;
      error_q   <= 1'b0;
    end else begin
      reads_q   <= reads_d;
      writes_q  <= writes_d;
      latency_q <= latency_d;
      error_q   <= error_d;
    end
  end

  assign mem_reads_o     = reads_q;
  assign mem_writes_o    = writes_q;
  assign mem_latency_o   = latency_q;
  assign pending_reads_o = pending;
  assign perf_error_o    = error_q;

endmodule

// File: tb/tb_vx_mem_perf_tracker.sv
// Drives a default-width and a narrow tracker with the same handshake traffic against a counter model.
module tb_vx_mem_perf_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, clear = 1'b0;
  logic req_v = 1'b0, req_rw = 1'b0, req_rdy = 1'b0, rsp_v = 1'b0, rsp_rdy = 1'b0;

  logic [43:0] a_reads, a_writes, a_lat;
  logic [7:0]  a_pend;
  logic        a_err;
  logic [3:0]  b_reads, b_writes, b_lat;
  logic [1:0]  b_pend;
  logic        b_err;

  vx_mem_perf_tracker u_dut_a (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .mem_req_valid_i (req_v),
    .mem_req_rw_i    (req_rw),
    .mem_req_ready_i (req_rdy),
    .mem_rsp_valid_i (rsp_v),
    .mem_rsp_ready_i (rsp_rdy),
    .mem_reads_o     (a_reads),
    .mem_writes_o    (a_writes),
    .mem_latency_o   (a_lat),
    .pending_reads_o (a_pend),
    .perf_error_o    (a_err)
  );

  vx_mem_perf_tracker #(
    .PerfCtrBits (4),
    .PendingBits (2)
  ) u_dut_b (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .mem_req_valid_i (req_v),
    .mem_req_rw_i    (req_rw),
    .mem_req_ready_i (req_rdy),
    .mem_rsp_valid_i (rsp_v),
    .mem_rsp_ready_i (rsp_rdy),
    .mem_reads_o     (b_reads),
    .mem_writes_o    (b_writes),
    .mem_latency_o   (b_lat),
    .pending_reads_o (b_pend),
    .perf_error_o    (b_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state, index 0 = default instance (44/8), index 1 = narrow instance (4/2).
  bit [63:0]   m_reads[2], m_writes[2], m_lat[2], m_pend[2];
  bit          m_err[2];
  int unsigned cw[2] = '{44, 4};
  int unsigned pw[2] = '{8, 2};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_reads[k] = 0; m_writes[k] = 0; m_lat[k] = 0; m_pend[k] = 0; m_err[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    bit rf, wf, sf, ovf;
    bit [63:0] cmask, pmax;
    rf = req_v & req_rdy & ~req_rw;
    wf = req_v & req_rdy & req_rw;
    sf = rsp_v & rsp_rdy;
    for (int k = 0; k < 2; k++) begin
      cmask = (64'd1 << cw[k]) - 64'd1;
      pmax  = (64'd1 << pw[k]) - 64'd1;
      if (!rst_n) begin
        m_reads[k] = 0; m_writes[k] = 0; m_lat[k] = 0; m_pend[k] = 0; m_err[k] = 1'b0;
      end else begin
        ovf = 1'b0;
        m_lat[k]    = clear ? 64'd0 : ((m_lat[k] + m_pend[k]) & cmask);
        m_reads[k]  = clear ? 64'd0 : ((m_reads[k] + 64'(rf)) & cmask);
        m_writes[k] = clear ? 64'd0 : ((m_writes[k] + 64'(wf)) & cmask);
        if (rf && !sf) begin
          if (m_pend[k] == pmax) ovf = 1'b1;
          else m_pend[k] = m_pend[k] + 1;
        end else if (sf && !rf) begin
          if (m_pend[k] == 0) ovf = 1'b1;
          else m_pend[k] = m_pend[k] - 1;
        end
        m_err[k] = clear ? 1'b0 : (m_err[k] | ovf);
      end
    end
  end

  task automatic check(input string name, input bit [63:0] act, input bit [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("A.reads",   64'(a_reads),  m_reads[0]);
      check("A.writes",  64'(a_writes), m_writes[0]);
      check("A.latency", 64'(a_lat),    m_lat[0]);
      check("A.pending", 64'(a_pend),   m_pend[0]);
      check("A.error",   64'(a_err),    64'(m_err[0]));
      check("B.reads",   64'(b_reads),  m_reads[1]);
      check("B.writes",  64'(b_writes), m_writes[1]);
      check("B.latency", 64'(b_lat),    m_lat[1]);
      check("B.pending", 64'(b_pend),   m_pend[1]);
      check("B.error",   64'(b_err),    64'(m_err[1]));
    end
  end

  task automatic tick(input logic v, input logic rw, input logic rdy, input logic sv,
                      input logic sr, input logic cl);
    req_v = v; req_rw = rw; req_rdy = rdy; rsp_v = sv; rsp_rdy = sr; clear = cl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd();    tick(1, 0, 1, 0, 0, 0); endtask
  task automatic wr();    tick(1, 1, 1, 0, 0, 0); endtask
  task automatic rsp();   tick(0, 0, 0, 1, 1, 0); endtask
  task automatic rdrsp(); tick(1, 0, 1, 1, 1, 0); endtask
  task automatic clr();   tick(0, 0, 0, 0, 0, 1); endtask

  initial begin
    rst_n = 1'b0;
    idle(1);
    chk_en = 1'b1;
    idle(1);
    rst_n = 1'b1;
    check("lit.reset.reads", 64'(a_reads), 0);
    check("lit.reset.pend",  64'(a_pend),  0);
    check("lit.reset.err",   64'(a_err),   0);

    // Valid without ready on either channel must not count.
    tick(1, 0, 0, 1, 0, 0);
    check("lit.stall.reads", 64'(a_reads), 0);
    check("lit.stall.err",   64'(a_err),   0);

    // Three non-overlapping reads, each answered 5 cycles after its fire.
    for (int i = 0; i < 3; i++) begin
      rd(); idle(4); rsp();
    end
    check("lit.r033.reads", 64'(a_reads), 3);
    check("lit.r033.lat",   64'(a_lat),   15);
    check("lit.r033.pend",  64'(a_pend),  0);
    check("lit.r033.err",   64'(a_err),   0);
    check("lit.r033.blat",  64'(b_lat),   15);
    clr();
    check("lit.clr.lat",   64'(a_lat),   0);
    check("lit.clr.reads", 64'(a_reads), 0);

    // Four back-to-back reads, responses starting 2 cycles after the last fire.
    for (int i = 0; i < 4; i++) rd();
    idle(1);
    for (int i = 0; i < 4; i++) rsp();
    check("lit.r034.lat",   64'(a_lat),   20);
    check("lit.r034.reads", 64'(a_reads), 4);
    check("lit.r034.pend",  64'(a_pend),  0);
    check("lit.r034.berr",  64'(b_err),   1);
    clr();
    check("lit.clr2.lat",  64'(a_lat), 0);
    check("lit.clr2.berr", 64'(b_err), 0);

    // Simultaneous read fire and response at pending=2.
    rd(); rd();
    check("lit.r035.pend0", 64'(a_pend), 2);
    rdrsp();
    check("lit.r035.pend",  64'(a_pend),  2);
    check("lit.r035.reads", 64'(a_reads), 3);
    rsp(); rsp();

    // Response with nothing outstanding, sticky error, then clear.
    clr();
    rsp();
    check("lit.r036.err",  64'(a_err),  1);
    check("lit.r036.pend", 64'(a_pend), 0);
    idle(2);
    check("lit.r036.sticky", 64'(a_err), 1);
    clr();
    check("lit.r036.clr.err",   64'(a_err),   0);
    check("lit.r036.clr.reads", 64'(a_reads), 0);
    check("lit.r036.clr.lat",   64'(a_lat),   0);

    // Clear does not block an event in the same cycle from reaching pending.
    tick(1, 0, 1, 0, 0, 1);
    check("lit.clrev.reads", 64'(a_reads), 0);
    check("lit.clrev.pend",  64'(a_pend),  1);
    rsp();

    // Narrow instance wrap and saturation.
    clr();
    for (int i = 0; i < 17; i++) wr();
    check("lit.r037.bwrites", 64'(b_writes), 1);
    check("lit.r037.awrites", 64'(a_writes), 17);
    for (int i = 0; i < 4; i++) rd();
    check("lit.r037.bpend", 64'(b_pend), 3);
    check("lit.r037.berr",  64'(b_err),  1);
    check("lit.r037.apend", 64'(a_pend), 4);
    check("lit.r037.aerr",  64'(a_err),  0);

    // Reset with reads outstanding and a read firing in the reset cycle.
    rsp(); rsp();
    check("lit.r038.pend0", 64'(a_pend), 2);
    rst_n = 1'b0;
    rd();
    rst_n = 1'b1;
    check("lit.r038.reads",  64'(a_reads),  0);
    check("lit.r038.writes", 64'(a_writes), 0);
    check("lit.r038.lat",    64'(a_lat),    0);
    check("lit.r038.pend",   64'(a_pend),   0);
    check("lit.r038.err",    64'(a_err),    0);
    rd(); idle(2); rsp();
    check("lit.r038.post.reads", 64'(a_reads), 1);
    check("lit.r038.post.lat",   64'(a_lat),   3);
    check("lit.r038.post.pend",  64'(a_pend),  0);
    rsp();
    check("lit.r038.post.err", 64'(a_err), 1);
    idle(1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
